lcd_scroll_multi: RTL and testbench



---
 rtl/lcd_scroll_multi_pkg.sv | 19 +
 rtl/lcd_scroll_multi_if.sv | 33 +++
 rtl/lcd_scroll_multi_color_map.sv | 32 +++
 rtl/lcd_scroll_multi.sv | 116 +++++++++++
 tb/tb_lcd_scroll_multi.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_scroll_multi_pkg.sv
// Shared constants for the multi-channel scrolling spectrum renderer:
// colour-mode encodings, scroll directions and default panel geometry.
package lcd_pkg;

  localparam logic [1:0] MODE_MAP  = 2'd0;
  localparam logic [1:0] MODE_GREY = 2'd1;
  localparam logic [1:0] MODE_THR  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int H_ACTIVE   = 480;
  localparam int V_ACTIVE   = 272;
  localparam int DEF_X0     = 96;
  localparam int DEF_PITCH  = 192;
  localparam int DEF_BAND_W = 96;

endpackage

// File: rtl/lcd_scroll_multi_if.sv
// Sample-RAM / timing-generator side signals of the renderer, bundled so the
// pixel-clock block can be wired with a single port.
interface lcd_scroll_multi_if #(
  parameter int NCH = 2,
  parameter int DW  = 12,
  parameter int AW  = 9,
  parameter int LW  = 9,
  parameter int PW  = 10
);
  logic [NCH*DW-1:0] data;
  logic [AW-1:0]     addr;
  logic              valid;
  logic [LW-1:0]     line;
  logic [PW-1:0]     pxl;
  logic [1:0]        mode;
  logic              dir;
  logic              freeze;
  logic [DW-1:0]     thresh;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic [AW-1:0]     read;

  modport master (
    output data, addr, valid, line, pxl, mode, dir, freeze, thresh,
    input  red, green, blue, read
  );

  modport slave (
    input  data, addr, valid, line, pxl, mode, dir, freeze, thresh,
    output red, green, blue, read
  );
endinterface

// File: rtl/lcd_scroll_multi_color_map.sv
// Combinational sample-to-RGB mapping for one active channel; odd channels
// use the colour map with red and blue exchanged so adjacent bands differ.
module lcd_color_map
  import lcd_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic [DW-1:0] i_d,
  input  logic [1:0]    i_mode,
  input  logic          i_odd,
  input  logic [DW-1:0] i_thresh,
  output logic [23:0]   o_rgb
);

  logic [7:0] w_hi;
  logic [7:0] w_mid;
  logic [7:0] w_lo;

  always_comb begin
    w_hi  = {i_d[DW-1 -: 6], 2'b00};
    w_mid = {i_d[DW-7 -: 4], 4'b0000};
    w_lo  = {3'b000, i_d[1:0], 3'b000};
    o_rgb = 24'h000000;
    case (i_mode)
      MODE_MAP:  o_rgb = i_odd ? {w_lo, w_mid, w_hi} : {w_hi, w_mid, w_lo};
      MODE_GREY: o_rgb = {3{i_d[DW-1 -: 8]}};
      MODE_THR:  o_rgb = (i_d >= i_thresh) ? 24'hFFFFFF : 24'h000000;
      default:   o_rgb = 24'h000000;
    endcase
  end

endmodule

// File: rtl/lcd_scroll_multi.sv
// Multi-channel spectrum renderer: band decode and colour output plus the
// circular read-address generator for a scrolling waterfall display.
module lcd_scroll_multi
  import lcd_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int DW     = 12,
  parameter int AW     = 9,
  parameter int DEPTH  = V_ACTIVE,
  parameter int LW     = 9,
  parameter int PW     = 10,
  parameter int X0     = DEF_X0,
  parameter int PITCH  = DEF_PITCH,
  parameter int BAND_W = DEF_BAND_W
) (
  input  logic             clk,
  input  logic             rst_n,
  lcd_scroll_multi_if.slave bus
);

  localparam logic [AW:0]   DEPTH_A = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] DEPTH_S = (AW+2)'(DEPTH);

  logic [AW-1:0]   r_first;
  logic [AW-1:0]   r_read;
  logic            r_dir;
  logic [1:0]      r_mode;
  logic [AW+1:0]   r_sum;
  logic [23:0]     r_rgb;

  logic            w_frame;
  logic [AW-1:0]   w_addr_fold;
  logic [AW-1:0]   w_first;
  logic            w_dir;
  logic [1:0]      w_mode;
  logic [AW+1:0]   w_sum;
  logic [NCH-1:0]  w_in;
  logic [31:0]     w_sel;
  logic            w_hit;
  logic            w_odd;
  logic [DW-1:0]   w_d;
  logic [23:0]     w_rgb;

  assign w_frame = (bus.line == {LW{1'b0}});

  // Line 0 bypasses the frame registers so its own read address already uses the new origin.
  always_comb begin
    w_addr_fold = ({1'b0, bus.addr} >= DEPTH_A) ? AW'({1'b0, bus.addr} - DEPTH_A) : bus.addr;
    if (w_frame && !bus.freeze) begin
      w_first = w_addr_fold;
    end else begin
      w_first = r_first;
    end
    if (w_frame) begin
      w_dir  = bus.dir;
      w_mode = bus.mode;
    end else begin
      w_dir  = r_dir;
      w_mode = r_mode;
    end
    if (w_dir == DIR_UP) begin
      w_sum = {2'b00, w_first} + DEPTH_S - (AW+2)'(bus.line);
    end else begin
      w_sum = {2'b00, w_first} + (AW+2)'(bus.line);
    end
  end

  // Band decode: iterate downward so the lowest-numbered overlapping band wins.
  always_comb begin
    w_in = {NCH{1'b0}};
    for (int c = 0; c < NCH; c++) begin
      w_in[c] = (32'(bus.pxl) >= 32'(X0 + c*PITCH)) &&
                (32'(bus.pxl) <= 32'(X0 + c*PITCH + BAND_W - 1));
    end
    w_sel = 32'd0;
    for (int c = NCH - 1; c >= 0; c--) begin
      w_sel = w_in[c] ? 32'(c) : w_sel;
    end
    w_hit = |w_in;
    w_odd = w_sel[0];
    w_d   = bus.data[w_sel*DW +: DW];
  end

  lcd_color_map #(.DW(DW)) u_color_map (
    .i_d      (w_d),
    .i_mode   (r_mode),
    .i_odd    (w_odd),
    .i_thresh (bus.thresh),
    .o_rgb    (w_rgb)
  );

  // Frame state, two-stage address fold and registered pixel colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first <= {AW{1'b0}};
      r_dir   <= 1'b0;
      r_mode  <= 2'b00;
      r_sum   <= {(AW+2){1'b0}};
      r_read  <= {AW{1'b0}};
      r_rgb   <= 24'h000000;
    end else begin
      r_first <= w_first;
      r_dir   <= w_dir;
      r_mode  <= w_mode;
      r_sum   <= w_sum;
      r_read  <= (r_sum >= DEPTH_S) ? AW'(r_sum - DEPTH_S) : AW'(r_sum);
      r_rgb   <= (bus.valid && w_hit) ? w_rgb : 24'h000000;
    end
  end

  assign bus.red   = r_rgb[23:16];
  assign bus.green = r_rgb[15:8];
  assign bus.blue  = r_rgb[7:0];
  assign bus.read  = r_read;

endmodule

// File: tb/tb_lcd_scroll_multi.sv
// Directed-vector bench for lcd_scroll_multi: scrolling address, band decode,
// colour modes, freeze and asynchronous reset.
module tb_lcd_scroll_multi;

  localparam int NCH = 2;
  localparam int DW  = 12;
  localparam int AW  = 9;
  localparam int LW  = 9;
  localparam int PW  = 10;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  lcd_scroll_multi_if #(.NCH(NCH), .DW(DW), .AW(AW), .LW(LW), .PW(PW)) bus ();

  lcd_scroll_multi #(.NCH(NCH), .DW(DW), .AW(AW), .LW(LW), .PW(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #55 clk = ~clk;

  task automatic latch_frame(input logic [1:0] m, input logic d, input logic f,
                             input logic [AW-1:0] a);
    @(negedge clk);
    bus.line = 9'd0; bus.mode = m; bus.dir = d; bus.freeze = f; bus.addr = a;
    @(negedge clk);
    bus.line = 9'd1;
  endtask

  task automatic drive_px(input logic v, input logic [PW-1:0] p, input logic [DW-1:0] d0,
                          input logic [DW-1:0] d1);
    @(negedge clk);
    bus.valid = v; bus.pxl = p; bus.data = {d1, d0};
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input logic [LW-1:0] l);
    @(negedge clk);
    bus.line = l;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.data = '0; bus.addr = '0; bus.valid = 1'b0; bus.line = 9'd5; bus.pxl = '0;
    bus.mode = 2'd0; bus.dir = 1'b0; bus.freeze = 1'b0; bus.thresh = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.red, bus.green, bus.blue} !== 24'h0 || bus.read !== 9'd0) begin
      n_err++;
      $display("FAIL reset rgb=%h read=%0d expected 000000/0", {bus.red, bus.green, bus.blue}, bus.read);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scroll_down();
    int exp_r;
    latch_frame(2'd0, 1'b0, 1'b0, 9'd100);
    for (int l = 0; l < 272; l++) begin
      set_line(9'(l));
      exp_r = (100 + l >= 272) ? 100 + l - 272 : 100 + l;
      n_vec++;
      if (bus.read !== 9'(exp_r)) begin
        n_err++;
        $display("FAIL down line=%0d read=%0d expected %0d", l, bus.read, exp_r);
      end
    end
  endtask

  task automatic test_scroll_up();
    logic [LW-1:0] l_t [4];
    logic [AW-1:0] r_t [4];
    l_t = '{9'd0, 9'd1, 9'd5, 9'd6};
    r_t = '{9'd5, 9'd4, 9'd0, 9'd271};
    latch_frame(2'd0, 1'b1, 1'b0, 9'd5);
    for (int i = 0; i < 4; i++) begin
      set_line(l_t[i]);
      n_vec++;
      if (bus.read !== r_t[i]) begin
        n_err++;
        $display("FAIL up line=%0d read=%0d expected %0d", l_t[i], bus.read, r_t[i]);
      end
    end
    latch_frame(2'd0, 1'b0, 1'b0, 9'd100);
  endtask

  task automatic test_fold();
    logic [LW-1:0] l_t [3];
    logic [AW-1:0] r_t [3];
    l_t = '{9'd0, 9'd243, 9'd244};
    r_t = '{9'd28, 9'd271, 9'd0};
    latch_frame(2'd0, 1'b0, 1'b0, 9'd300);
    for (int i = 0; i < 3; i++) begin
      set_line(l_t[i]);
      n_vec++;
      if (bus.read !== r_t[i]) begin
        n_err++;
        $display("FAIL fold line=%0d read=%0d expected %0d", l_t[i], bus.read, r_t[i]);
      end
    end
  endtask

  task automatic test_colour_map();
    logic [PW-1:0] p_t [12];
    logic          v_t [12];
    logic [23:0]   e_t [12];
    p_t = '{10'd100, 10'd300, 10'd200, 10'd96, 10'd95, 10'd191,
            10'd192, 10'd288, 10'd287, 10'd383, 10'd384, 10'd100};
    v_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    e_t = '{24'hA8F000, 24'h188010, 24'h000000, 24'hA8F000, 24'h000000, 24'hA8F000,
            24'h000000, 24'h188010, 24'h000000, 24'h188010, 24'h000000, 24'h000000};
    latch_frame(2'd0, 1'b0, 1'b0, 9'd0);
    for (int i = 0; i < 12; i++) begin
      drive_px(v_t[i], p_t[i], 12'hABC, 12'h123);
      n_vec++;
      if ({bus.red, bus.green, bus.blue} !== e_t[i]) begin
        n_err++;
        $display("FAIL map pxl=%0d valid=%0b rgb=%h expected %h", p_t[i], v_t[i],
                 {bus.red, bus.green, bus.blue}, e_t[i]);
      end
    end
  endtask

  task automatic test_grey();
    latch_frame(2'd1, 1'b0, 1'b0, 9'd0);
    drive_px(1'b1, 10'd100, 12'hABC, 12'h123);
    n_vec++;
    if ({bus.red, bus.green, bus.blue} !== 24'hABABAB) begin
      n_err++;
      $display("FAIL grey0 rgb=%h expected ababab", {bus.red, bus.green, bus.blue});
    end
    drive_px(1'b1, 10'd300, 12'hABC, 12'h123);
    n_vec++;
    if ({bus.red, bus.green, bus.blue} !== 24'h121212) begin
      n_err++;
      $display("FAIL grey1 rgb=%h expected 121212", {bus.red, bus.green, bus.blue});
    end
  endtask

  task automatic test_threshold();
    logic [PW-1:0] p_t [5];
    logic [DW-1:0] d0_t [5];
    logic [DW-1:0] d1_t [5];
    logic [23:0]   e_t [5];
    p_t  = '{10'd100, 10'd100, 10'd100, 10'd300, 10'd300};
    d0_t = '{12'h7FF, 12'h800, 12'hFFF, 12'h000, 12'h000};
    d1_t = '{12'h000, 12'h000, 12'h000, 12'h123, 12'h800};
    e_t  = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
    bus.thresh = 12'h800;
    latch_frame(2'd2, 1'b0, 1'b0, 9'd0);
    for (int i = 0; i < 5; i++) begin
      drive_px(1'b1, p_t[i], d0_t[i], d1_t[i]);
      n_vec++;
      if ({bus.red, bus.green, bus.blue} !== e_t[i]) begin
        n_err++;
        $display("FAIL thr[%0d] rgb=%h expected %h", i, {bus.red, bus.green, bus.blue}, e_t[i]);
      end
    end
    @(negedge clk);
    bus.line = 9'd5; bus.mode = 2'd3;
    drive_px(1'b1, 10'd100, 12'h800, 12'h000);
    n_vec++;
    if ({bus.red, bus.green, bus.blue} !== 24'hFFFFFF) begin
      n_err++;
      $display("FAIL midframe rgb=%h expected ffffff", {bus.red, bus.green, bus.blue});
    end
    latch_frame(2'd3, 1'b0, 1'b0, 9'd0);
    drive_px(1'b1, 10'd100, 12'h800, 12'hFFF);
    n_vec++;
    if ({bus.red, bus.green, bus.blue} !== 24'h000000) begin
      n_err++;
      $display("FAIL rsvd0 rgb=%h expected 000000", {bus.red, bus.green, bus.blue});
    end
    drive_px(1'b1, 10'd300, 12'h800, 12'hFFF);
    n_vec++;
    if ({bus.red, bus.green, bus.blue} !== 24'h000000) begin
      n_err++;
      $display("FAIL rsvd1 rgb=%h expected 000000", {bus.red, bus.green, bus.blue});
    end
  endtask

  task automatic test_freeze();
    latch_frame(2'd0, 1'b0, 1'b0, 9'd40);
    set_line(9'd3);
    n_vec++;
    if (bus.read !== 9'd43) begin
      n_err++;
      $display("FAIL frz_base read=%0d expected 43", bus.read);
    end
    @(negedge clk);
    bus.freeze = 1'b1; bus.addr = 9'd90;
    set_line(9'd0);
    n_vec++;
    if (bus.read !== 9'd40) begin
      n_err++;
      $display("FAIL frz_hold0 read=%0d expected 40", bus.read);
    end
    set_line(9'd3);
    n_vec++;
    if (bus.read !== 9'd43) begin
      n_err++;
      $display("FAIL frz_hold3 read=%0d expected 43", bus.read);
    end
    @(negedge clk);
    bus.freeze = 1'b0;
    set_line(9'd0);
    n_vec++;
    if (bus.read !== 9'd90) begin
      n_err++;
      $display("FAIL frz_rel0 read=%0d expected 90", bus.read);
    end
    set_line(9'd3);
    n_vec++;
    if (bus.read !== 9'd93) begin
      n_err++;
      $display("FAIL frz_rel3 read=%0d expected 93", bus.read);
    end
  endtask

  task automatic test_async_reset();
    latch_frame(2'd1, 1'b0, 1'b0, 9'd100);
    @(negedge clk);
    bus.valid = 1'b1; bus.pxl = 10'd100; bus.data = {12'h123, 12'hABC};
    set_line(9'd150);
    n_vec++;
    if (bus.read !== 9'd250 || {bus.red, bus.green, bus.blue} !== 24'hABABAB) begin
      n_err++;
      $display("FAIL pre_rst read=%0d rgb=%h expected 250/ababab", bus.read, {bus.red, bus.green, bus.blue});
    end
    @(negedge clk);
    #20 rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.read !== 9'd0 || {bus.red, bus.green, bus.blue} !== 24'h0) begin
      n_err++;
      $display("FAIL async_rst read=%0d rgb=%h expected 0/000000", bus.read, {bus.red, bus.green, bus.blue});
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_line(9'd150);
    n_vec++;
    if (bus.read !== 9'd150 || {bus.red, bus.green, bus.blue} !== 24'hA8F000) begin
      n_err++;
      $display("FAIL post_rst read=%0d rgb=%h expected 150/a8f000", bus.read, {bus.red, bus.green, bus.blue});
    end
    latch_frame(2'd0, 1'b0, 1'b0, 9'd100);
    set_line(9'd150);
    n_vec++;
    if (bus.read !== 9'd250) begin
      n_err++;
      $display("FAIL relatch read=%0d expected 250", bus.read);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_scroll_down();
    test_scroll_up();
    test_fold();
    test_colour_map();
    test_grey();
    test_threshold();
    test_freeze();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
